ara_pe_req_fanout: RTL

Buffered broadcast controller between the sequencer and the processing elements (lanes, load, store, slide, mask units). It accepts one `pe_req_t` per cycle into a small FIFO and presents the head entry to every targeted PE. Each PE may accept in a different cycle, and the entry retires only once all targeted PEs have accepted. While an entry waits, its hazard bits are pruned against the running-instruction vector, so a retired vector-instruction ID never produces a stale dependency.

---
 rtl/ara_pe_req_fanout.sv | 116 +++++++++++
 1 files changed

// File: rtl/ara_pe_req_fanout.sv
// Buffered broadcast of sequencer requests to the processing elements.
// Each entry retires once every targeted PE has accepted it; hazards are pruned while it waits.
package ara_pe_pkg;
    localparam int unsigned NrVInsn = 8;

    typedef struct packed {
        logic [2:0]         vid;
        logic [7:0]         op;
        logic [NrVInsn-1:0] hazard_vs1;
        logic [NrVInsn-1:0] hazard_vs2;
        logic [NrVInsn-1:0] hazard_vd;
        logic [NrVInsn-1:0] hazard_vm;
        logic [NrVInsn-1:0] vinsn_running;
    } pe_req_t;
endpackage

module ara_pe_req_fanout
    import ara_pe_pkg::*;
#(
    parameter int unsigned NrLanes = 1,
    parameter int unsigned NrPEs   = NrLanes + 4,
    parameter int unsigned Depth   = 2,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW   = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  pe_req_t            req_i,
    input  logic [NrPEs-1:0]   req_target_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [NrVInsn-1:0] vinsn_running_i,
    output pe_req_t            pe_req_o,
    output logic [NrPEs-1:0]   pe_req_valid_o,
    input  logic [NrPEs-1:0]   pe_req_ready_i,
    output logic [CntW-1:0]    count_o,
    output logic               empty_o
);

    pe_req_t          mem_q  [Depth];
    logic [NrPEs-1:0] pend_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic             empty, push, pop;
    logic [NrPEs-1:0] pend_head, hs;

    function automatic pe_req_t prune(pe_req_t r, logic [NrVInsn-1:0] run);
        pe_req_t o;
        o            = r;
        o.hazard_vs1 = r.hazard_vs1 & run;
        o.hazard_vs2 = r.hazard_vs2 & run;
        o.hazard_vd  = r.hazard_vd  & run;
        o.hazard_vm  = r.hazard_vm  & run;
        return o;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty          = (count_q == '0);
        pend_head      = pend_q[rd_ptr_q];
        pe_req_valid_o = empty ? '0 : pend_head;
        hs             = pe_req_valid_o & pe_req_ready_i;
        pop            = !empty && ((pend_head & ~hs) == '0);
        req_ready_o    = (count_q != CntW'(Depth));
        push           = req_valid_i && req_ready_o;

        pe_req_o = '0;
        if (!empty) begin
            pe_req_o               = prune(mem_q[rd_ptr_q], vinsn_running_i);
            pe_req_o.vinsn_running = vinsn_running_i;
        end

        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        count_o = count_q;
        empty_o = empty;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            // Free slots are pruned too; their contents are never observed.
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= prune(mem_q[i], vinsn_running_i);
            end
            if (!empty) begin
                pend_q[rd_ptr_q] <= pend_head & ~hs;
            end
            // A push never targets the live head slot, so it can safely follow.
            if (push) begin
                mem_q[wr_ptr_q]  <= prune(req_i, vinsn_running_i);
                pend_q[wr_ptr_q] <= req_target_i;
            end
        end
    end

endmodule
